// File: rtl/ibex_data_bus_sram_responder_if.sv
// Ibex data bus: request/grant channel plus one-cycle response channel.
// Core side uses master, memory-side responders use slave.
interface ibex_data_bus;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/ibex_data_bus_sram_responder.sv
// Data-bus responder in front of a 1-cycle synchronous SRAM, with
// programmable grant wait states and out-of-window error responses.
module ibex_data_bus_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int unsigned SIZE_BYTES  = 4096,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW =
    (SIZE_BYTES > 4) ? $clog2(SIZE_BYTES / 4) : 1
) (
  input  logic          clk,
  input  logic          rst,
  ibex_data_bus.slave   data_bus,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic        gnt;
  logic        accept;
  logic        in_range;
  logic [32:0] addr_w;
  logic [32:0] lo;
  logic [32:0] hi;
  logic [31:0] off;

  // 33-bit compare so a window at the top of memory cannot wrap
  assign addr_w   = {1'b0, data_bus.addr[31:2], 2'b00};
  assign lo       = {1'b0, ADDR_BASE};
  assign hi       = lo + 33'(SIZE_BYTES);
  assign in_range = (addr_w >= lo) && (addr_w < hi);
  assign off      = data_bus.addr - ADDR_BASE;

  always_comb begin
    gnt = 1'b0;
    if (!rst) begin
      if (WAIT_STATES == 0) begin
        gnt = data_bus.req && (state_q == IDLE);
      end else begin
        gnt = data_bus.req && (state_q == WAIT)
              && (cnt_q == 4'd0);
      end
    end
  end

  assign accept = data_bus.req && gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if ((WAIT_STATES > 0) && data_bus.req) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!data_bus.req || (cnt_q == 4'd0)) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    rvalid_d = accept;
    load_d   = accept && in_range && !data_bus.we;
    err_d    = accept && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  // Response is masked during reset so a pending beat never escapes
  assign data_bus.gnt    = gnt;
  assign data_bus.rvalid = rvalid_q && !rst;
  assign data_bus.err    = err_q && !rst;
  assign data_bus.rdata  =
    (rvalid_q && load_q && !rst) ? mem_rdata : 32'd0;

  assign mem_req   = accept && in_range;
  assign mem_we    = mem_req && data_bus.we;
  assign mem_addr  = off[AW+1:2];
  assign mem_be    = data_bus.be;
  assign mem_wdata = data_bus.wdata;

  logic unused_ok;
  assign unused_ok = ^{off[31:AW+2], off[1:0], data_bus.addr[1:0]};

endmodule

// File: tb/tb_ibex_data_bus_sram_responder.sv
// Bench for ibex_data_bus_sram_responder: one instance with no wait
// states, one with three, sharing a behavioural SRAM.
module tb_ibex_data_bus_sram_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          SIZE  = 4096;
  localparam int          WORDS = SIZE / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  int n_asrt = 0;
  int n_fail = 0;

  ibex_data_bus bus0 ();
  ibex_data_bus bus3 ();

  assign bus0.req   = req & ~sel;
  assign bus0.addr  = addr;
  assign bus0.we    = we;
  assign bus0.be    = be;
  assign bus0.wdata = wdata;
  assign bus3.req   = req & sel;
  assign bus3.addr  = addr;
  assign bus3.we    = we;
  assign bus3.be    = be;
  assign bus3.wdata = wdata;

  logic        m0_req, m0_we, m3_req, m3_we;
  logic [9:0]  m0_addr, m3_addr;
  logic [3:0]  m0_be, m3_be;
  logic [31:0] m0_wdata, m3_wdata;
  logic [31:0] m_rdata;

  ibex_data_bus_sram_responder #(
    .ADDR_BASE(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .data_bus(bus0),
    .mem_req(m0_req), .mem_we(m0_we), .mem_addr(m0_addr),
    .mem_be(m0_be), .mem_wdata(m0_wdata), .mem_rdata(m_rdata)
  );

  ibex_data_bus_sram_responder #(
    .ADDR_BASE(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(3)
  ) dut3 (
    .clk(clk), .rst(rst), .data_bus(bus3),
    .mem_req(m3_req), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_be(m3_be), .mem_wdata(m3_wdata), .mem_rdata(m_rdata)
  );

  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        m_req, m_we;
  logic [9:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;

  assign gnt     = sel ? bus3.gnt    : bus0.gnt;
  assign rvalid  = sel ? bus3.rvalid : bus0.rvalid;
  assign err     = sel ? bus3.err    : bus0.err;
  assign rdata   = sel ? bus3.rdata  : bus0.rdata;
  assign m_req   = m0_req | m3_req;
  assign m_we    = sel ? m3_we    : m0_we;
  assign m_addr  = sel ? m3_addr  : m0_addr;
  assign m_be    = sel ? m3_be    : m0_be;
  assign m_wdata = sel ? m3_wdata : m0_wdata;

  logic [31:0] sram [WORDS] = '{default: '0};

  always @(posedge clk) begin
    if (m_req) begin
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_be[i]) sram[m_addr][8*i +: 8] <= m_wdata[8*i +: 8];
      end else begin
        m_rdata <= sram[m_addr];
      end
    end
  end

  logic [31:0] ref_mem [WORDS];

  function automatic logic in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) &&
           (longint'(a) < longint'(BASE) + SIZE);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     input int ws, output logic [31:0] rd_obs);
    int n;
    int idx;
    logic inr;
    logic [31:0] exp_rd;
    inr    = in_win(a);
    idx    = inr ? int'((a - BASE) >> 2) : 0;
    exp_rd = 32'd0;
    rd_obs = 32'd0;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt === 1'b1) break;
      chk("mreq_before_gnt", 32'(m_req), 32'd0);
      n++;
      if (n > 40) begin
        chk("gnt_timeout", 32'(gnt), 32'd1);
        req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("gnt_latency", n, ws);
    chk("mem_req", 32'(m_req), 32'(inr));
    if (inr) begin
      chk("mem_addr", 32'(m_addr), idx);
      chk("mem_we", 32'(m_we), 32'(w));
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp_rd = ref_mem[idx];
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("err", 32'(err), 32'(!inr));
    chk("rdata", rdata, exp_rd);
    chk("mreq_after", 32'(m_req), 32'd0);
    rd_obs = rdata;
    @(negedge clk);
    chk("rvalid_drop", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic        s;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
    rst = 1'b1; sel = 1'b0; req = 1'b0; we = 1'b0;
    addr = 32'd0; be = 4'd0; wdata = 32'd0;

    // reset state, including a request held during reset
    repeat (2) @(posedge clk);
    #1 req = 1'b1; addr = BASE;
    @(negedge clk);
    chk("rst_gnt0", 32'(bus0.gnt), 32'd0);
    chk("rst_mreq0", 32'(m0_req), 32'd0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid0", 32'(bus0.rvalid), 32'd0);
    chk("rst_err0", 32'(bus0.err), 32'd0);
    chk("rst_rdata0", bus0.rdata, 32'd0);
    chk("rst_rvalid3", 32'(bus3.rvalid), 32'd0);
    chk("rst_gnt3", 32'(bus3.gnt), 32'd0);
    chk("rst_mwe", 32'(m0_we | m3_we), 32'd0);

    // store then load, no wait states
    txn(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 0, rd);
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, rd);
    chk("ws0_load", rd, 32'hDEAD_BEEF);

    // three wait states
    sel = 1'b1;
    txn(1'b0, BASE, 4'hF, 32'h0, 3, rd);
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 3, rd);
    chk("ws3_load", rd, 32'hDEAD_BEEF);

    // req dropped while waiting: no grant, no response
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = BASE + 32'h10;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_gnt", 32'(gnt), 32'd0);
      chk("abort_rvalid", 32'(rvalid), 32'd0);
    end
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 3, rd);

    // out of window
    txn(1'b0, BASE + 32'h1000, 4'hF, 32'h0, 3, rd);
    sel = 1'b0;
    txn(1'b0, BASE + 32'h1000, 4'hF, 32'h0, 0, rd);
    txn(1'b0, BASE - 32'h4, 4'hF, 32'h0, 0, rd);
    txn(1'b1, BASE + 32'h2000, 4'hF, 32'h1234_5678, 0, rd);

    // byte lanes, and an all-lanes-off store
    txn(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, 0, rd);
    txn(1'b1, BASE + 32'h20, 4'b0010, 32'h0000_AA00, 0, rd);
    txn(1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, rd);
    chk("byte_lane", rd, 32'h1122_AA44);
    txn(1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF, 0, rd);
    txn(1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, rd);
    chk("be0_store", rd, 32'h1122_AA44);

    // back-to-back loads with req held
    for (int k = 0; k < 8; k++)
      txn(1'b1, BASE + 32'h100 + 32'(4 * k), 4'hF,
          $urandom, 0, rd);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + 32'h100;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        chk("b2b_gnt", 32'(gnt), 32'd1);
        chk("b2b_maddr", 32'(m_addr), 32'(64 + k));
      end
      if (k > 0) begin
        chk("b2b_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_rdata", rdata, ref_mem[64 + k - 1]);
      end
      @(posedge clk); #1;
      if (k < 7) addr = BASE + 32'h100 + 32'(4 * (k + 1));
      else req = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end", 32'(rvalid), 32'd0);

    // reset between accept and response
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = BASE + 32'h10;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_gnt0", 32'(gnt), 32'd0);
      chk("mid_rst_mreq", 32'(m_req), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    txn(1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, rd);
    chk("post_rst_load", rd, 32'hDEAD_BEEF);

    // random mix against the reference memory
    for (int t = 0; t < 40; t++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = BASE + 32'(SIZE) + 32'($urandom_range(0, 255));
        1: a = BASE - 32'd4 - 32'($urandom_range(0, 255));
        default: a = BASE + 32'($urandom_range(0, SIZE - 1));
      endcase
      sel = s;
      txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
          s ? 3 : 0, rd);
    end
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
